// File: rtl/uart_rx_collector.sv
// rtl/uart_rx_collector.sv - UART byte receiver feeding a 4-entry FIFO drained by a PCI-side reader
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous active-high reset
//   rx        - asynchronous UART line, idle high
//   state     - PCI transaction state, 3'd0 = idle; bytes are offered only when idle
//   rd        - pop the head byte (honoured only while valid)
//   data      - FIFO head byte
//   valid     - FIFO non-empty and PCI idle
//   workload  - number of bits sampled so far in the current frame (0..9)
//   frame_err - one-cycle pulse when a stop bit samples low
//   overrun   - one-cycle pulse when a good byte is dropped on a full FIFO
module uart_rx_collector #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [2:0] state,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic [5:0] workload,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [9:0] FULL_LAST = 10'(CLKS_PER_BIT - 1);
  localparam logic [9:0] HALF_LAST = 10'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} fsm_t;

  fsm_t       fsm;
  logic       sync1, rxs, rxs_d;
  logic [9:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [3:0] wl;

  logic [7:0] mem [FIFO_DEPTH];
  logic [1:0] wp, rp;
  logic [2:0] count;
  logic       push, pop, full, accept;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  // Reset to 1 so that releasing reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      wl        <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (fsm)
        IDLE: begin
          wl      <= '0;
          cnt     <= '0;
          bit_idx <= '0;
          // A true 1->0 transition is required; a line held low does not re-arm.
          if (rxs_d && !rxs) fsm <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rxs) begin
              fsm <= DATA;
              wl  <= 4'd1;
            end else begin
              fsm <= IDLE;
            end
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            wl      <= wl + 4'd1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) fsm <= STOP;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            wl  <= '0;
            fsm <= IDLE;
            if (!rxs) frame_err <= 1'b1;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign workload = {2'b00, wl};

  // shreg already holds all eight data bits by the time the stop bit is sampled.
  assign push   = (fsm == STOP) && (cnt == FULL_LAST) && rxs;
  assign valid  = (count != 3'd0) && (state == 3'd0);
  assign pop    = rd && valid;
  assign full   = (count == 3'(FIFO_DEPTH));
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign accept = push && (!full || pop);
  assign data   = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun <= push && full && !pop;
      if (accept) begin
        mem[wp] <= shreg;
        wp      <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      case ({accept, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_collector.md
UART_RX_COLLECTOR -- requirements
Module: uart_rx_collector

Parameters
REQ-001 SHALL provide CLKS_PER_BIT, default 16, giving clk cycles per UART bit; legal values are even and 4..1024.
REQ-002 SHALL provide FIFO_DEPTH, fixed at 4, giving receive byte buffer entries.

Interface
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx, input, 1 bit: UART serial line, asynchronous, idle high.
REQ-006 SHALL have port state, input, 3 bits: PCI transaction state; 3'd0 = idle.
REQ-007 SHALL have port rd, input, 1 bit: PCI side pops the head byte.
REQ-008 SHALL have port data, output, 8 bits: head byte of the FIFO.
REQ-009 SHALL have port valid, output, 1 bit: head byte may be taken by PCI.
REQ-010 SHALL have port workload, output, 6 bits: bits sampled in the current frame.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 SHALL synchronise rx through two flops; all decisions use the synchronised value (rxs) and its one-cycle-delayed copy.
REQ-014 SHALL implement FSM states IDLE, START, DATA and STOP.
REQ-015 SHALL leave IDLE for START only on a falling edge of rxs (previous 1, current 0), so a line stuck low never restarts a frame.
REQ-016 SHALL, in START, sample rxs CLKS_PER_BIT/2 cycles after the edge; 0 -> DATA with workload=1; 1 -> IDLE, treated as a glitch with no outputs.
REQ-017 SHALL, in DATA, sample every CLKS_PER_BIT cycles, 8 bits LSB first, incrementing workload per sample (2..9); after bit 7 -> STOP.
REQ-018 SHALL, in STOP, sample after CLKS_PER_BIT cycles and return to IDLE with workload=0.
REQ-019 SHALL, if the STOP sample is 1, push the byte into the FIFO on that edge.
REQ-020 SHALL, if the STOP sample is 0, discard the byte and pulse frame_err for one cycle.
REQ-021 SHALL hold workload at 0 in IDLE and never exceed 9.
REQ-022 SHALL drive valid combinationally as (FIFO count != 0) and (state == 3'd0).
REQ-023 SHALL drive data from the FIFO head; data is don't-care when count=0.
REQ-024 SHALL pop on a rising edge with rd=1 and valid=1; rd with valid=0 has no effect.
REQ-025 SHALL, on a push when count=FIFO_DEPTH with no pop that cycle, drop the byte, pulse overrun and leave FIFO contents unchanged.
REQ-026 SHALL, on simultaneous push and pop, do both; count is unchanged, including at full, where no overrun occurs.
REQ-027 SHALL use wrap-around read and write pointers of 2 bits with a 3-bit count (0..4).
REQ-028 SHALL produce valid on the cycle after the STOP-sample edge when state=0 and the FIFO was empty.

Reset
REQ-029 SHALL, while rst=1, asynchronously force FSM=IDLE, both synchroniser flops=1, delayed rxs=1, pointers=0, count=0, shift register=0, bit/cycle counters=0.
REQ-030 SHALL, while rst=1, hold outputs at data=8'h00, valid=0, workload=0, frame_err=0, overrun=0.
REQ-031 SHALL, on reset mid-frame, abandon the partial frame; after release a new frame needs a fresh falling edge.

Verification (CLKS_PER_BIT=16, state=0 unless noted)
REQ-032 SHALL be tested with frame 0xA5 with a good stop bit -> workload steps 1..9 then 0; data=8'hA5 and valid=1 one cycle after the stop sample; rd=1 for one cycle -> valid=0.
REQ-033 SHALL be tested with rx low for 4 cycles then high -> FSM returns to IDLE; valid, frame_err and workload stay 0.
REQ-034 SHALL be tested with frame 0x3C with stop bit 0 -> frame_err high exactly 1 cycle, count stays 0; next frame 0x11 (after rx high) -> received correctly.
REQ-035 SHALL be tested with 5 good frames 0x01..0x05 and no rd -> overrun pulses once on the 5th; pops return 0x01..0x04 in order.
REQ-036 SHALL be tested with FIFO holding 0x77 and state=3'd2 -> valid=0 and rd ignored; state to 0 -> valid=1 and data=8'h77 the same cycle.
REQ-037 SHALL be tested with rst pulsed during data bit 4 of a frame -> all outputs reset at once; the rest of the frame is ignored; the next full frame 0xC3 is received.
